mdu_div_seq: RTL and testbench

MDU_DIV_SEQ -- requirements
Module: mdu_div_seq

---
 rtl/mdu_div_seq_pkg.sv | 32 +++
 rtl/mdu_div_seq_div_iter_step.sv | 22 ++
 rtl/mdu_div_seq.sv | 163 ++++++++++++++++
 tb/tb_mdu_div_seq.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_div_seq_pkg.sv
// Shared definitions for the sequential RISC-V divider.
// Op encodings, FSM states, iteration count and the latched-operation context.
package mdu_div_seq_pkg;

    localparam int DIV_ITER = 32;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } div_state_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [4:0]  rd;
        logic        div0;
        logic        ovf;
        logic        neg_quo;
        logic        neg_rem;
        logic [31:0] dvd;
    } div_ctx_t;

    function automatic logic [31:0] neg_if(input logic c, input logic [31:0] v);
        return c ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mdu_div_seq_div_iter_step.sv
// One restoring shift-subtract step on unsigned magnitudes.
// Shifts the next dividend bit into the partial remainder and emits one quotient bit.
module div_iter_step (
    input  logic [31:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] rem_o,
    output logic [31:0] quo_o
);

    logic [32:0] shf;
    logic [32:0] diff;

    // Trial subtract; a clear borrow bit means the divisor fits.
    always_comb begin
        shf   = {rem_i, quo_i[31]};
        diff  = shf - {1'b0, divisor_i};
        rem_o = diff[32] ? shf[31:0] : diff[31:0];
        quo_o = {quo_i[30:0], ~diff[32]};
    end

endmodule

// File: rtl/mdu_div_seq.sv
// Sequential 32-bit divider (DIV/DIVU/REM/REMU), one iteration per cycle.
// Define MDU_EARLY_OUT_EN to skip CALC for divide-by-zero and signed overflow.
module mdu_div_seq
    import mdu_div_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic [31:0] result_o,
    output logic        result_valid_o,
    output logic [4:0]  rd_addr_o
);

    localparam logic [4:0] CNT_LAST = 5'(DIV_ITER - 1);

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    div_ctx_t    ctx_q, ctx_d;
    logic [31:0] res_q, res_d;
    logic [4:0]  rdo_q, rdo_d;

    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic        sgn;
    logic        a_neg;
    logic        b_neg;
    logic        div0_s;
    logic        ovf_s;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic [31:0] res_fin;
    logic        fire;

    div_iter_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // Classify the incoming request: signedness and the special cases.
    always_comb begin
        sgn    = ~op_i[0];
        a_neg  = sgn & dividend_i[31];
        b_neg  = sgn & divisor_i[31];
        div0_s = (divisor_i == 32'd0);
        ovf_s  = sgn & (dividend_i == 32'h8000_0000)
                     & (divisor_i == 32'hFFFF_FFFF);
    end

    // Fix up signs and force the special-case results.
    always_comb begin
        q_fin = neg_if(ctx_q.neg_quo, quo_q);
        r_fin = neg_if(ctx_q.neg_rem, rem_q);
        if (ctx_q.div0) begin
            q_fin = 32'hFFFF_FFFF;
            r_fin = ctx_q.dvd;
        end else if (ctx_q.ovf) begin
            q_fin = 32'h8000_0000;
            r_fin = 32'd0;
        end
        res_fin = ctx_q.op[1] ? r_fin : q_fin;
    end

    // Outputs: write strobe in DONE, otherwise hold the last written values.
    always_comb begin
        fire           = (state_q == S_DONE) & ~flush_i;
        result_valid_o = fire;
        result_o       = fire ? res_fin : res_q;
        rd_addr_o      = fire ? ctx_q.rd : rdo_q;
        busy_o         = ((state_q == S_IDLE) & start_i)
                       | (state_q == S_CALC);
    end

    // Next-state logic for the FSM and the iteration datapath.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        ctx_d   = ctx_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    state_d       = S_CALC;
                    cnt_d         = 5'd0;
                    rem_d         = 32'd0;
                    quo_d         = neg_if(a_neg, dividend_i);
                    dvs_d         = neg_if(b_neg, divisor_i);
                    ctx_d.op      = op_i;
                    ctx_d.rd      = rd_addr_i;
                    ctx_d.div0    = div0_s;
                    ctx_d.ovf     = ovf_s;
                    ctx_d.neg_quo = a_neg ^ b_neg;
                    ctx_d.neg_rem = a_neg;
                    ctx_d.dvd     = dividend_i;
`ifdef MDU_EARLY_OUT_EN
                    if (div0_s || ovf_s) begin
                        state_d = S_DONE;
                    end
`endif
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    quo_d = step_quo;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                if (!flush_i) begin
                    res_d = res_fin;
                    rdo_d = ctx_q.rd;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            ctx_q   <= '0;
            res_q   <= 32'd0;
            rdo_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            ctx_q   <= ctx_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

endmodule

// File: tb/tb_mdu_div_seq.sv
// Self-checking bench for mdu_div_seq.
// Scoreboard of expected results, pushed at start and popped on result_valid_o.
module tb_mdu_div_seq;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  rd_addr_i;
    logic        flush_i;
    logic        busy_o;
    logic [31:0] result_o;
    logic        result_valid_o;
    logic [4:0]  rd_addr_o;

    exp_t sb[$];
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    mdu_div_seq dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .op_i           (op_i),
        .dividend_i     (dividend_i),
        .divisor_i      (divisor_i),
        .rd_addr_i      (rd_addr_i),
        .flush_i        (flush_i),
        .busy_o         (busy_o),
        .result_o       (result_o),
        .result_valid_o (result_valid_o),
        .rd_addr_o      (rd_addr_o)
    );

    function automatic bit is_special(input logic [1:0] op,
                                      input logic [31:0] a,
                                      input logic [31:0] b);
        return (b == 32'd0) ||
               (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] model(input logic [1:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[1] ? 32'd0 : 32'h8000_0000;
        case (op)
            2'b00:   return $signed(a) / $signed(b);
            2'b01:   return a / b;
            2'b10:   return $signed(a) % $signed(b);
            default: return a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
        return is_special(op, a, b) ? 0 : 32;
`else
        return is_special(op, a, b) ? 32 : 32;
`endif
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        exp_t e;
        int   idx;
        bit   found;
        bit   busy_bad;
        @(negedge clk);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        #1;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_req got=%b exp=1", busy_o);
        end
        e.res = model(op, a, b);
        e.rd  = rd;
        e.lat = exp_lat(op, a, b);
        sb.push_back(e);
        @(posedge clk);
        #1;
        start_i    = 1'b0;
        dividend_i = $urandom;
        divisor_i  = $urandom;
        rd_addr_i  = 5'($urandom);
        op_i       = 2'($urandom);
        found      = 1'b0;
        busy_bad   = 1'b0;
        idx        = 0;
        while (!found && idx <= 40) begin
            if (result_valid_o === 1'b1) begin
                found = 1'b1;
                e = sb.pop_front();
                tests_run++;
                if (result_o !== e.res) begin
                    tests_failed++;
                    $display("FAIL result op=%0d a=%h b=%h got=%h exp=%h",
                             op, a, b, result_o, e.res);
                end
                tests_run++;
                if (rd_addr_o !== e.rd) begin
                    tests_failed++;
                    $display("FAIL rd_addr got=%0d exp=%0d", rd_addr_o, e.rd);
                end
                tests_run++;
                if (idx != e.lat) begin
                    tests_failed++;
                    $display("FAIL latency a=%h b=%h got=%0d exp=%0d",
                             a, b, idx, e.lat);
                end
                tests_run++;
                if (busy_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL busy_done got=%b exp=0", busy_o);
                end
            end else begin
                if (busy_o !== 1'b1) busy_bad = 1'b1;
                start_i = (idx == 4);
                @(posedge clk);
                #1;
                start_i = 1'b0;
                idx++;
            end
        end
        if (!found) begin
            tests_run++;
            tests_failed++;
            $display("FAIL timeout a=%h b=%h got=no_valid exp=valid", a, b);
            void'(sb.pop_front());
        end
        tests_run++;
        if (busy_bad) begin
            tests_failed++;
            $display("FAIL busy_calc got=0 exp=1");
        end
        @(posedge clk);
        #1;
        tests_run++;
        if (result_valid_o !== 1'b0 || result_o !== e.res ||
            rd_addr_o !== e.rd) begin
            tests_failed++;
            $display("FAIL hold got=%b/%h/%0d exp=0/%h/%0d",
                     result_valid_o, result_o, rd_addr_o, e.res, e.rd);
        end
    endtask

    task automatic start_only(input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        rd_addr_i  = rd;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        op_i       = 2'b00;
        dividend_i = 32'd0;
        divisor_i  = 32'd0;
        rd_addr_i  = 5'd0;
        #12;
        tests_run++;
        if (result_o !== 32'd0 || rd_addr_o !== 5'd0 ||
            result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_out got=%h/%0d/%b/%b exp=0/0/0/0",
                     result_o, rd_addr_o, result_valid_o, busy_o);
        end
        start_i = 1'b1;
        #1;
        tests_run++;
        if (busy_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_busy got=%b exp=1", busy_o);
        end
        start_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned;
        run_op(2'b01, 32'd100, 32'd7, 5'd3);
        run_op(2'b11, 32'd100, 32'd7, 5'd4);
        run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 5'd5);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    endtask

    task automatic test_signed;
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd7);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd8);
        run_op(2'b00, 32'd7, 32'hFFFF_FFFE, 5'd9);
        run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 5'd10);
    endtask

    task automatic test_div_zero;
        run_op(2'b00, 32'd5, 32'd0, 5'd11);
        run_op(2'b11, 32'd5, 32'd0, 5'd12);
        run_op(2'b10, 32'hFFFF_FFFB, 32'd0, 5'd13);
        run_op(2'b01, 32'd0, 32'd0, 5'd14);
    endtask

    task automatic test_overflow;
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);
    endtask

    task automatic test_flush_calc;
        bit seen;
        start_only(2'b01, 32'd1000, 32'd3, 5'd17);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (result_valid_o === 1'b1) seen = 1'b1;
        end
        flush_i = 1'b1;
        #1;
        if (result_valid_o === 1'b1) seen = 1'b1;
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b0 || result_valid_o !== 1'b0 || seen) begin
            tests_failed++;
            $display("FAIL flush_calc got=%b/%b/%b exp=0/0/0",
                     busy_o, result_valid_o, seen);
        end
        run_op(2'b00, 32'd1000, 32'd3, 5'd18);
    endtask

    task automatic test_flush_done;
        logic [31:0] pre_res;
        logic [4:0]  pre_rd;
        pre_res = result_o;
        pre_rd  = rd_addr_o;
        start_only(2'b01, 32'd77, 32'd5, 5'd19);
        repeat (32) @(posedge clk);
        #1;
        flush_i = 1'b1;
        #1;
        tests_run++;
        if (result_valid_o !== 1'b0 || result_o !== pre_res ||
            rd_addr_o !== pre_rd) begin
            tests_failed++;
            $display("FAIL flush_done got=%b/%h/%0d exp=0/%h/%0d",
                     result_valid_o, result_o, rd_addr_o, pre_res, pre_rd);
        end
        @(posedge clk);
        #1;
        flush_i = 1'b0;
        tests_run++;
        if (result_valid_o !== 1'b0 || busy_o !== 1'b0 ||
            result_o !== pre_res) begin
            tests_failed++;
            $display("FAIL flush_done_after got=%b/%b/%h exp=0/0/%h",
                     result_valid_o, busy_o, result_o, pre_res);
        end
    endtask

    task automatic test_reset_mid;
        bit seen;
        run_op(2'b01, 32'd12345, 32'd10, 5'd21);
        start_only(2'b01, 32'd999, 32'd4, 5'd22);
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (result_o !== 32'd0 || rd_addr_o !== 5'd0 ||
            result_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid got=%h/%0d/%b/%b exp=0/0/0/0",
                     result_o, rd_addr_o, result_valid_o, busy_o);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (result_valid_o === 1'b1) seen = 1'b1;
        end
        tests_run++;
        if (seen) begin
            tests_failed++;
            $display("FAIL reset_mid_valid got=1 exp=0");
        end
        run_op(2'b11, 32'd999, 32'd4, 5'd23);
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 12; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            run_op(2'(i), a, b, 5'($urandom));
        end
    endtask

    initial begin
        test_reset;
        test_unsigned;
        test_signed;
        test_div_zero;
        test_overflow;
        test_flush_calc;
        test_flush_done;
        test_reset_mid;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
